// File: rtl/filter_pkg.sv
// Shared constants, FSM state encoding and border-mask helper for the
// 5x5 convolution frame sequencer.
package filter_pkg;

    localparam int KERNEL   = 5;
    localparam int HALF     = 2;
    localparam int NUM_TAPS = 25;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    // Bit k is set when offset k-HALF from pos still lands inside [0, dim-1].
    function automatic logic [KERNEL-1:0] edge_mask(input int pos, input int dim);
        logic [KERNEL-1:0] m;
        m = '0;
        for (int k = 0; k < KERNEL; k++) begin
            m[k] = ((pos + k - HALF) >= 0) && ((pos + k - HALF) <= (dim - 1));
        end
        return m;
    endfunction

endpackage

// File: rtl/filter_coef_bank.sv
// Double-buffered 25-tap coefficient bank: writes land in the shadow copy,
// load moves shadow to active with a same-cycle write forwarded.
module filter_coef_bank
    import filter_pkg::*;
#(
    parameter int COEF_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [4:0]                     addr,
    input  logic [COEF_WIDTH-1:0]          data,
    input  logic                           load,
    output logic [NUM_TAPS*COEF_WIDTH-1:0] coef
);

    logic [COEF_WIDTH-1:0] shadow [NUM_TAPS];
    logic [COEF_WIDTH-1:0] active [NUM_TAPS];

    // Addresses 25..31 match no tap, so they fall through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_TAPS; n++) begin
                shadow[n] <= '0;
                active[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_TAPS; n++) begin
                if (we && (addr == 5'(n))) begin
                    shadow[n] <= data;
                end
                if (load) begin
                    active[n] <= (we && (addr == 5'(n))) ? data : shadow[n];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
        assign coef[g*COEF_WIDTH +: COEF_WIDTH] = active[g];
    end

endmodule

// File: rtl/filter_conv_seq.sv
// Frame sequencer for the 5x5 convolution datapath.
//   state | meaning
//   IDLE  | waiting for a start with legal dimensions
//   RUN   | accepting W*H raster pixels, shifting on each accept
//   FLUSH | shifting 2W+2 times with no input to push out the last centers
//   DRAIN | two cycles letting the final o_en / o_y_valid retire
//   DONE  | one-cycle completion pulse
module filter_conv_seq
    import filter_pkg::*;
#(
    parameter int COEF_WIDTH = 8,
    parameter int DIM_WIDTH  = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [DIM_WIDTH-1:0]           i_width,
    input  logic [DIM_WIDTH-1:0]           i_height,
    input  logic                           i_coef_we,
    input  logic [4:0]                     i_coef_addr,
    input  logic [COEF_WIDTH-1:0]          i_coef_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic                           o_shift,
    output logic                           o_en,
    output logic [KERNEL-1:0]              o_row_mask,
    output logic [KERNEL-1:0]              o_col_mask,
    output logic [DIM_WIDTH-1:0]           o_row,
    output logic [DIM_WIDTH-1:0]           o_col,
    output logic [NUM_TAPS*COEF_WIDTH-1:0] o_coef,
    output logic                           o_y_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err
);

    localparam int CNT_WIDTH = 2*DIM_WIDTH + 1;

    state_t                 state, state_nxt;
    logic [DIM_WIDTH-1:0]   w_q, h_q, cen_row, cen_col;
    logic [CNT_WIDTH-1:0]   s_cnt, n_pix, n_lag, n_total;
    logic                   drain_cnt, dims_ok, start_acc, shift, produce;
    logic                   en_q, yv_q, err_q;
    logic [KERNEL-1:0]      row_mask_q, col_mask_q;
    logic [DIM_WIDTH-1:0]   row_q, col_q;

    assign dims_ok   = (i_width >= DIM_WIDTH'(KERNEL)) && (i_height >= DIM_WIDTH'(KERNEL));
    assign start_acc = (state == IDLE) && i_start && dims_ok;
    assign n_pix     = CNT_WIDTH'(w_q) * CNT_WIDTH'(h_q);
    assign n_lag     = (CNT_WIDTH'(w_q) << 1) + CNT_WIDTH'(2);
    assign n_total   = n_pix + n_lag;
    assign shift     = !i_abort && (((state == RUN) && i_valid) || (state == FLUSH));
    // A center exists once the window has advanced past two rows plus two pixels.
    assign produce   = shift && (s_cnt >= n_lag);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = RUN;
            RUN:     if (shift && (s_cnt == n_pix - 1'b1)) state_nxt = FLUSH;
            FLUSH:   if (s_cnt == n_total - 1'b1) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if ((state != IDLE) && i_abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= '0;
            h_q        <= '0;
            s_cnt      <= '0;
            cen_row    <= '0;
            cen_col    <= '0;
            drain_cnt  <= 1'b0;
            en_q       <= 1'b0;
            yv_q       <= 1'b0;
            err_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            row_mask_q <= '0;
            col_mask_q <= '0;
        end else begin
            err_q <= (state == IDLE) && i_start && !dims_ok;
            en_q  <= produce;
            yv_q  <= en_q && !i_abort;
            if (start_acc) begin
                w_q       <= i_width;
                h_q       <= i_height;
                s_cnt     <= '0;
                cen_row   <= '0;
                cen_col   <= '0;
                drain_cnt <= 1'b0;
            end else begin
                if (shift) s_cnt <= s_cnt + 1'b1;
                if (state == DRAIN) drain_cnt <= ~drain_cnt;
            end
            if (produce) begin
                row_q      <= cen_row;
                col_q      <= cen_col;
                row_mask_q <= edge_mask(int'(cen_row), int'(h_q));
                col_mask_q <= edge_mask(int'(cen_col), int'(w_q));
                if (cen_col == w_q - 1'b1) begin
                    cen_col <= '0;
                    cen_row <= cen_row + 1'b1;
                end else begin
                    cen_col <= cen_col + 1'b1;
                end
            end else begin
                row_q      <= '0;
                col_q      <= '0;
                row_mask_q <= '0;
                col_mask_q <= '0;
            end
        end
    end

    filter_coef_bank #(.COEF_WIDTH(COEF_WIDTH)) u_coef_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (i_coef_we),
        .addr (i_coef_addr),
        .data (i_coef_data),
        .load (start_acc),
        .coef (o_coef)
    );

    assign o_ready    = (state == RUN);
    assign o_shift    = shift;
    assign o_en       = en_q;
    assign o_y_valid  = yv_q;
    assign o_row      = row_q;
    assign o_col      = col_q;
    assign o_row_mask = row_mask_q;
    assign o_col_mask = col_mask_q;
    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);
    assign o_err      = err_q;

endmodule

// File: tb/tb_filter_conv_seq.sv
// Directed bench for filter_conv_seq: frame timing, raster order, masks,
// coefficient double buffering, bad dimensions, abort and mid-frame reset.
module tb_filter_conv_seq;
    logic         clk = 1'b0;
    logic         rst, i_start, i_abort, i_coef_we, i_valid;
    logic [10:0]  i_width, i_height;
    logic [4:0]   i_coef_addr;
    logic [7:0]   i_coef_data;
    logic         o_ready, o_shift, o_en, o_y_valid, o_busy, o_done, o_err;
    logic [4:0]   o_row_mask, o_col_mask;
    logic [10:0]  o_row, o_col;
    logic [199:0] o_coef;

    int total = 0;
    int bad = 0;

    // frame statistics gathered by run_frame
    int n_acc, n_flush, n_en, n_yv, raster_errs, bad_en;
    int first_en_cyc, shift13_cyc, last_shift_cyc, done_cyc;
    logic [4:0] rm_first, cm_first, rm_last, cm_last, rm_11, cm_11, rm_22, cm_22;
    bit timeout;

    filter_conv_seq #(.COEF_WIDTH(8), .DIM_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_width(i_width), .i_height(i_height), .i_coef_we(i_coef_we),
        .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_shift(o_shift), .o_en(o_en), .o_row_mask(o_row_mask),
        .o_col_mask(o_col_mask), .o_row(o_row), .o_col(o_col), .o_coef(o_coef),
        .o_y_valid(o_y_valid), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tap(input int n);
        return o_coef[n*8 +: 8];
    endfunction

    // Called and returns at posedge+1 with the DUT idle.
    task automatic run_frame(input int w, input int h, input bit toggle);
        int cyc, nsh, er, ec;
        bit prev_shift, done_seen;
        n_acc = 0; n_flush = 0; n_en = 0; n_yv = 0; raster_errs = 0; bad_en = 0;
        first_en_cyc = -1; shift13_cyc = -1; last_shift_cyc = -1; done_cyc = -1;
        rm_first = 'x; cm_first = 'x; rm_last = 'x; cm_last = 'x;
        rm_11 = 'x; cm_11 = 'x; rm_22 = 'x; cm_22 = 'x;
        i_width = 11'(w); i_height = 11'(h); i_start = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 0; nsh = 0; er = 0; ec = 0; prev_shift = 1'b0; done_seen = 1'b0;
        while (!done_seen && cyc < 2000) begin
            i_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (o_shift) begin
                if (o_ready) n_acc++; else n_flush++;
                nsh++;
                if (nsh == 13) shift13_cyc = cyc;
                last_shift_cyc = cyc;
            end
            if (o_en) begin
                n_en++;
                if (first_en_cyc < 0) begin
                    first_en_cyc = cyc; rm_first = o_row_mask; cm_first = o_col_mask;
                end
                if (!prev_shift) bad_en++;
                if (o_row !== 11'(er) || o_col !== 11'(ec)) raster_errs++;
                if (er == 1 && ec == 1) begin rm_11 = o_row_mask; cm_11 = o_col_mask; end
                if (er == 2 && ec == 2) begin rm_22 = o_row_mask; cm_22 = o_col_mask; end
                rm_last = o_row_mask; cm_last = o_col_mask;
                if (ec == w - 1) begin ec = 0; er++; end else ec++;
            end
            if (o_y_valid) n_yv++;
            if (o_done) begin done_cyc = cyc; done_seen = 1'b1; end
            prev_shift = o_shift;
            @(posedge clk); #1;
            cyc++;
        end
        i_valid = 1'b0;
        timeout = !done_seen;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 0; i_abort = 0; i_coef_we = 0; i_valid = 0;
        i_width = 0; i_height = 0; i_coef_addr = 0; i_coef_data = 0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (o_coef !== 200'd0) begin bad++; $display("FAIL reset_coef got=%h want=0", o_coef); end
        total++; if ({o_ready, o_shift, o_en, o_y_valid, o_busy, o_done, o_err} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000000", {o_ready, o_shift, o_en, o_y_valid, o_busy, o_done, o_err}); end
        total++; if ({o_row, o_col, o_row_mask, o_col_mask} !== 32'd0) begin
            bad++; $display("FAIL reset_coord got=%h want=0", {o_row, o_col, o_row_mask, o_col_mask}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_5x5();
        run_frame(5, 5, 1'b0);
        total++; if (timeout) begin bad++; $display("FAIL b5_timeout got=1 want=0"); end
        total++; if (n_acc != 25) begin bad++; $display("FAIL b5_accepts got=%0d want=25", n_acc); end
        total++; if (n_flush != 12) begin bad++; $display("FAIL b5_flush got=%0d want=12", n_flush); end
        total++; if (n_en != 25) begin bad++; $display("FAIL b5_en got=%0d want=25", n_en); end
        total++; if (n_yv != 25) begin bad++; $display("FAIL b5_yvalid got=%0d want=25", n_yv); end
        total++; if (raster_errs != 0) begin bad++; $display("FAIL b5_raster got=%0d want=0", raster_errs); end
        total++; if (first_en_cyc != shift13_cyc + 1) begin
            bad++; $display("FAIL b5_first_en got=%0d want=%0d", first_en_cyc, shift13_cyc + 1); end
        total++; if ({rm_first, cm_first} !== 10'b11100_11100) begin
            bad++; $display("FAIL b5_mask00 got=%b want=1110011100", {rm_first, cm_first}); end
        total++; if ({rm_last, cm_last} !== 10'b00111_00111) begin
            bad++; $display("FAIL b5_mask44 got=%b want=0011100111", {rm_last, cm_last}); end
        total++; if ({rm_11, cm_11} !== 10'b11110_11110) begin
            bad++; $display("FAIL b5_mask11 got=%b want=1111011110", {rm_11, cm_11}); end
        total++; if ({rm_22, cm_22} !== 10'b11111_11111) begin
            bad++; $display("FAIL b5_mask22 got=%b want=1111111111", {rm_22, cm_22}); end
        total++; if (done_cyc != last_shift_cyc + 3) begin
            bad++; $display("FAIL b5_done got=%0d want=%0d", done_cyc, last_shift_cyc + 3); end
    endtask

    task automatic test_backpressure();
        run_frame(8, 6, 1'b1);
        total++; if (timeout) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
        total++; if (n_acc != 48) begin bad++; $display("FAIL bp_accepts got=%0d want=48", n_acc); end
        total++; if (n_flush != 18) begin bad++; $display("FAIL bp_flush got=%0d want=18", n_flush); end
        total++; if (n_en != 48) begin bad++; $display("FAIL bp_en got=%0d want=48", n_en); end
        total++; if (raster_errs != 0) begin bad++; $display("FAIL bp_raster got=%0d want=0", raster_errs); end
        total++; if (bad_en != 0) begin bad++; $display("FAIL bp_en_no_shift got=%0d want=0", bad_en); end
        total++; if ({rm_last, cm_last} !== 10'b00111_00111) begin
            bad++; $display("FAIL bp_mask_last got=%b want=0011100111", {rm_last, cm_last}); end
        total++; if ({rm_22, cm_22} !== 10'b11111_11111) begin
            bad++; $display("FAIL bp_mask22 got=%b want=1111111111", {rm_22, cm_22}); end
        total++; if (done_cyc != last_shift_cyc + 3) begin
            bad++; $display("FAIL bp_done got=%0d want=%0d", done_cyc, last_shift_cyc + 3); end
    endtask

    task automatic test_coef_bank();
        logic [199:0] exp_coef;
        i_coef_we = 1'b1; i_coef_addr = 5'd12; i_coef_data = 8'h11;
        @(posedge clk); #1;
        i_coef_addr = 5'd3; i_coef_data = 8'h7f;
        i_width = 11'd5; i_height = 11'd5; i_start = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0; i_coef_we = 1'b0;
        total++; if (tap(12) !== 8'h11) begin bad++; $display("FAIL cb_load12 got=%h want=11", tap(12)); end
        total++; if (tap(3) !== 8'h7f) begin bad++; $display("FAIL cb_bypass3 got=%h want=7f", tap(3)); end
        i_coef_we = 1'b1; i_coef_addr = 5'd12; i_coef_data = 8'h40;
        @(posedge clk); #1;
        i_coef_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tap(12) !== 8'h11) begin bad++; $display("FAIL cb_hold12 got=%h want=11", tap(12)); end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        total++; if (o_busy !== 1'b0 || tap(12) !== 8'h11) begin
            bad++; $display("FAIL cb_abort_keep busy=%b tap12=%h want busy=0 tap12=11", o_busy, tap(12)); end
        i_coef_we = 1'b1; i_coef_addr = 5'd25; i_coef_data = 8'h55;
        @(posedge clk); #1;
        i_coef_addr = 5'd31; i_coef_data = 8'h66;
        @(posedge clk); #1;
        i_coef_we = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        exp_coef = '0;
        exp_coef[3*8 +: 8] = 8'h7f;
        exp_coef[12*8 +: 8] = 8'h40;
        total++; if (o_coef !== exp_coef) begin bad++; $display("FAIL cb_reload got=%h want=%h", o_coef, exp_coef); end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
    endtask

    task automatic test_bad_dims();
        i_width = 11'd4; i_height = 11'd5; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total++; if ({o_err, o_busy, o_ready} !== 3'b100) begin
            bad++; $display("FAIL bd_w4 err_busy_ready got=%b want=100", {o_err, o_busy, o_ready}); end
        @(posedge clk); #1;
        total++; if ({o_err, o_busy, o_ready} !== 3'b000) begin
            bad++; $display("FAIL bd_w4_after got=%b want=000", {o_err, o_busy, o_ready}); end
        i_width = 11'd5; i_height = 11'd4; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total++; if ({o_err, o_busy} !== 2'b10) begin
            bad++; $display("FAIL bd_h4 err_busy got=%b want=10", {o_err, o_busy}); end
        i_height = 11'd5; i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        total++; if ({o_err, o_busy, o_ready} !== 3'b011) begin
            bad++; $display("FAIL bd_min_start got=%b want=011", {o_err, o_busy, o_ready}); end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
    endtask

    task automatic test_abort();
        int acc, done_cnt;
        i_width = 11'd5; i_height = 11'd5; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 50 && acc < 10; c++) begin
            #1;
            if (o_shift && o_ready) acc++;
            @(posedge clk); #1;
        end
        total++; if (acc != 10) begin bad++; $display("FAIL ab_accepts got=%0d want=10", acc); end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        #1;
        total++; if ({o_busy, o_ready, o_shift, o_en, o_y_valid} !== 5'b00000) begin
            bad++; $display("FAIL ab_idle got=%b want=00000", {o_busy, o_ready, o_shift, o_en, o_y_valid}); end
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (o_done) done_cnt++;
            @(posedge clk); #1;
        end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL ab_no_done got=%0d want=0", done_cnt); end
        i_valid = 1'b0;
        run_frame(5, 5, 1'b0);
        total++; if (timeout || n_en != 25 || n_acc != 25) begin
            bad++; $display("FAIL ab_restart en=%0d acc=%0d timeout=%0d want 25 25 0", n_en, n_acc, timeout); end
    endtask

    task automatic test_reset_flush();
        int fl;
        bit seen_en;
        i_coef_we = 1'b1; i_coef_addr = 5'd12; i_coef_data = 8'h40;
        i_width = 11'd5; i_height = 11'd5; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_coef_we = 1'b0; i_valid = 1'b1;
        fl = 0; seen_en = 1'b0;
        for (int c = 0; c < 60 && fl < 3; c++) begin
            #1;
            if (o_busy && !o_ready && o_shift) begin fl++; seen_en = o_en; end
            if (fl < 3) begin @(posedge clk); #1; end
        end
        total++; if (fl != 3 || !seen_en || tap(12) !== 8'h40) begin
            bad++; $display("FAIL rf_precond flush=%0d en=%b tap12=%h want 3 1 40", fl, seen_en, tap(12)); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (o_coef !== 200'd0) begin bad++; $display("FAIL rf_coef got=%h want=0", o_coef); end
        total++; if ({o_ready, o_shift, o_en, o_y_valid, o_busy, o_done, o_err, o_row, o_col, o_row_mask, o_col_mask} !== 39'd0) begin
            bad++; $display("FAIL rf_outputs got=%h want=0",
                {o_ready, o_shift, o_en, o_y_valid, o_busy, o_done, o_err, o_row, o_col, o_row_mask, o_col_mask}); end
        rst = 1'b0; i_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        total++; if (tap(12) !== 8'h00) begin bad++; $display("FAIL rf_shadow_clear got=%h want=00", tap(12)); end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_5x5();
        test_backpressure();
        test_coef_bank();
        test_bad_dims();
        test_abort();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
